fetch_seq: RTL and testbench

- Fetch sequencer that drives the program counter register's write enable and next-PC value, at RESET_PC=0x00003000, in the pipelined MIPS core.
- Selects the next PC from the sequential increment, a decode-stage branch/jump, an exception entry, or an ERET return.
- Holds exception/ERET redirects that arrive while the pipeline is stalled and applies them on the first unstalled cycle.
- Flags fetch addresses that fall outside instruction memory or are misaligned.

---
 rtl/fetch_seq.sv | 133 +++++++++++++
 tb/tb_fetch_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq -- fetch sequencer for the pipelined MIPS core.
//
// Chooses the next PC from four sources, highest priority first: exception
// entry, ERET return, decode-stage branch/jump, then sequential pc+4.
// It also drives the PC register write enable.
// An exception or ERET redirect that arrives while the pipeline is stalled
// is held, then applied on the first cycle with stall low.
// Fetch addresses that are misaligned or outside instruction memory are
// flagged on fetch_err.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal sequencing; redirects apply at once unless stalled
// PEND  | a stalled exception/ERET redirect is held in r_pend_target
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   pc[31:0]         in   current PC register value
//   stall            in   hazard stall, blocks the PC update
//   br_valid         in   decode holds a resolved branch/jump
//   br_taken         in   branch outcome (qualified by br_valid)
//   br_target[31:0]  in   branch/jump target
//   exc_req          in   exception request pulse (M stage)
//   eret_req         in   ERET request pulse (M stage)
//   epc[31:0]        in   ERET return address, valid with eret_req
//   npc[31:0]        out  next PC
//   pc_we            out  PC write enable
//   flush_fd         out  F/D flush, pulses when an exc/ERET redirect lands
//   redirect_pending out  a stalled redirect is waiting
//   fetch_err        out  pc misaligned or outside [IM_BASE, IM_LIMIT]
module fetch_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFF,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        flush_fd,
    output logic        redirect_pending,
    output logic        fetch_err
);

    typedef enum logic [0:0] {RUN  = 1'b0, PEND = 1'b1} state_t;
    typedef enum logic [0:0] {EXC  = 1'b0, ERET = 1'b1} kind_t;

    state_t      r_state;
    kind_t       r_pend_kind;
    logic [31:0] r_pend_target;

    logic [31:0] w_pc_inc;
    logic        w_pend;

    assign w_pc_inc = pc + 32'd4;
    assign w_pend   = (r_state == PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pend_kind   <= EXC;
            r_pend_target <= 32'h0;
        end else begin
            case (r_state)
                RUN: begin
                    if (stall) begin
                        if (exc_req) begin
                            r_state       <= PEND;
                            r_pend_kind   <= EXC;
                            r_pend_target <= HANDLER_PC;
                        end else if (eret_req) begin
                            r_state       <= PEND;
                            r_pend_kind   <= ERET;
                            r_pend_target <= epc;
                        end
                    end
                end
                PEND: begin
                    if (!stall) begin
                        r_state       <= RUN;
                        r_pend_kind   <= EXC;
                        r_pend_target <= 32'h0;
                    end else if (exc_req) begin
                        // An exception always wins over a held ERET.
                        r_pend_kind   <= EXC;
                        r_pend_target <= HANDLER_PC;
                    end else if (eret_req && r_pend_kind == ERET) begin
                        // A newer ERET replaces an older one; it never displaces an EXC.
                        r_pend_target <= epc;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        npc              = w_pc_inc;
        pc_we            = 1'b0;
        flush_fd         = 1'b0;
        redirect_pending = 1'b0;
        if (w_pend) begin
            // A simultaneous exception at release overrides the held target.
            // A simultaneous ERET does not.
            npc = (exc_req && !stall) ? HANDLER_PC : r_pend_target;
        end else if (exc_req) begin
            npc = HANDLER_PC;
        end else if (eret_req) begin
            npc = epc;
        end else if (br_valid && br_taken) begin
            npc = br_target;
        end
        if (!rst) begin
            pc_we            = !stall;
            redirect_pending = w_pend;
            // A taken branch keeps its delay slot, so only exc/ERET redirects flush.
            flush_fd         = !stall && (w_pend || exc_req || eret_req);
        end
    end

    assign fetch_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] IMB     = 32'h0000_3000;
    localparam logic [31:0] IML     = 32'h0000_6FFF;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid, br_taken, exc_req, eret_req;
    logic [31:0] pc, br_target, epc;
    logic [31:0] npc;
    logic        pc_we, flush_fd, redirect_pending, fetch_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_seq dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .npc(npc), .pc_we(pc_we), .flush_fd(flush_fd),
        .redirect_pending(redirect_pending), .fetch_err(fetch_err)
    );

    typedef struct {
        bit          rst, stall, brv;
        logic [31:0] pc, btgt;
        bit          exc, eret;
        logic [31:0] epc;
        bit          cnpc;
        logic [31:0] enpc;
        bit          we, fl, rp, err;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input bit r, input bit s, input logic [31:0] p, input bit b,
                     input logic [31:0] bt, input bit x, input bit e, input logic [31:0] ep,
                     input bit cn, input logic [31:0] en,
                     input bit we, input bit fl, input bit rp, input bit er);
        vec_t t;
        t.rst = r; t.stall = s; t.pc = p; t.brv = b; t.btgt = bt;
        t.exc = x; t.eret = e; t.epc = ep; t.cnpc = cn; t.enpc = en;
        t.we = we; t.fl = fl; t.rp = rp; t.err = er;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: an optional held redirect {is_exc, target}.
    bit          m_pend;
    bit          m_pend_exc;
    logic [31:0] m_tgt;

    function automatic logic [31:0] model_npc();
        if (m_pend) return (exc_req && !stall) ? HANDLER : m_tgt;
        if (exc_req) return HANDLER;
        if (eret_req) return epc;
        if (br_valid && br_taken) return br_target;
        return pc + 32'd4;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a < IMB) || (a > IML);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_pend = 0;
        end else if (m_pend) begin
            if (!stall) m_pend = 0;
            else if (exc_req) begin m_pend_exc = 1; m_tgt = HANDLER; end
            else if (eret_req && !m_pend_exc) m_tgt = epc;
        end else if (stall && exc_req) begin
            m_pend = 1; m_pend_exc = 1; m_tgt = HANDLER;
        end else if (stall && eret_req) begin
            m_pend = 1; m_pend_exc = 0; m_tgt = epc;
        end
    endtask

    initial begin
        rst = 1; stall = 0; br_valid = 0; br_taken = 0; exc_req = 0; eret_req = 0;
        pc = 32'h3000; br_target = 0; epc = 0;

        //  rst s  pc      brv btgt    x  e  epc      cn enpc     we fl rp er
        v(1, 0, 'h3000, 0, 0,      0, 0, 0,      0, 0,       0, 0, 0, 0);
        v(0, 0, 'h3000, 0, 0,      0, 0, 0,      1, 'h3004,  1, 0, 0, 0);
        v(0, 0, 'h3004, 0, 0,      0, 0, 0,      1, 'h3008,  1, 0, 0, 0);
        v(0, 0, 'h3008, 0, 0,      0, 0, 0,      1, 'h300C,  1, 0, 0, 0);
        v(0, 0, 'h3010, 1, 'h3100, 0, 0, 0,      1, 'h3100,  1, 0, 0, 0);
        v(0, 1, 'h3010, 1, 'h3100, 0, 0, 0,      0, 0,       0, 0, 0, 0);
        v(0, 0, 'h3010, 0, 0,      0, 0, 0,      1, 'h3014,  1, 0, 0, 0);
        v(0, 1, 'h3010, 0, 0,      0, 1, 'h3200, 0, 0,       0, 0, 0, 0);
        v(0, 1, 'h3010, 0, 0,      0, 0, 0,      1, 'h3200,  0, 0, 1, 0);
        v(0, 1, 'h3010, 0, 0,      0, 0, 0,      1, 'h3200,  0, 0, 1, 0);
        v(0, 1, 'h3010, 0, 0,      0, 0, 0,      1, 'h3200,  0, 0, 1, 0);
        v(0, 0, 'h3010, 1, 'h3100, 0, 0, 0,      1, 'h3200,  1, 1, 1, 0);
        v(0, 0, 'h3200, 0, 0,      0, 0, 0,      1, 'h3204,  1, 0, 0, 0);
        v(0, 1, 'h3204, 0, 0,      0, 1, 'h3200, 0, 0,       0, 0, 0, 0);
        v(0, 1, 'h3204, 0, 0,      1, 0, 0,      1, 'h3200,  0, 0, 1, 0);
        v(0, 1, 'h3204, 0, 0,      0, 0, 0,      1, 'h4180,  0, 0, 1, 0);
        v(0, 1, 'h3204, 0, 0,      0, 1, 'h3300, 1, 'h4180,  0, 0, 1, 0);
        v(0, 1, 'h3204, 0, 0,      0, 0, 0,      1, 'h4180,  0, 0, 1, 0);
        v(0, 0, 'h3204, 0, 0,      0, 0, 0,      1, 'h4180,  1, 1, 1, 0);
        v(0, 0, 'h4180, 1, 'h3100, 1, 1, 'h3500, 1, 'h4180,  1, 1, 0, 0);
        v(0, 0, 'h2FFC, 0, 0,      0, 0, 0,      1, 'h3000,  1, 0, 0, 1);
        v(0, 0, 'h7000, 0, 0,      0, 0, 0,      1, 'h7004,  1, 0, 0, 1);
        v(0, 0, 'h3002, 0, 0,      0, 0, 0,      1, 'h3006,  1, 0, 0, 1);
        v(0, 0, 'h6FFC, 0, 0,      0, 0, 0,      1, 'h7000,  1, 0, 0, 0);
        v(0, 1, 'h3000, 0, 0,      1, 0, 0,      0, 0,       0, 0, 0, 0);
        v(0, 1, 'h3000, 0, 0,      0, 0, 0,      1, 'h4180,  0, 0, 1, 0);
        v(1, 1, 'h3000, 0, 0,      0, 0, 0,      0, 0,       0, 0, 0, 0);
        v(0, 1, 'h3000, 0, 0,      0, 0, 0,      0, 0,       0, 0, 0, 0);
        v(0, 0, 'h3000, 0, 0,      0, 0, 0,      1, 'h3004,  1, 0, 0, 0);
        v(0, 1, 'h3004, 0, 0,      0, 1, 'h3200, 0, 0,       0, 0, 0, 0);
        v(0, 1, 'h3004, 0, 0,      0, 1, 'h3400, 1, 'h3200,  0, 0, 1, 0);
        v(0, 1, 'h3004, 0, 0,      0, 0, 0,      1, 'h3400,  0, 0, 1, 0);
        v(0, 0, 'h3004, 0, 0,      0, 1, 'h3500, 1, 'h3400,  1, 1, 1, 0);
        v(0, 0, 'h3400, 0, 0,      0, 0, 0,      1, 'h3404,  1, 0, 0, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; stall = vecs[i].stall; pc = vecs[i].pc;
            br_valid = vecs[i].brv; br_taken = vecs[i].brv; br_target = vecs[i].btgt;
            exc_req = vecs[i].exc; eret_req = vecs[i].eret; epc = vecs[i].epc;
            #4;
            if (vecs[i].cnpc) chk($sformatf("vec%0d npc", i), npc, vecs[i].enpc);
            chk($sformatf("vec%0d pc_we", i), {31'b0, pc_we}, {31'b0, vecs[i].we});
            chk($sformatf("vec%0d flush_fd", i), {31'b0, flush_fd}, {31'b0, vecs[i].fl});
            chk($sformatf("vec%0d redirect_pending", i), {31'b0, redirect_pending}, {31'b0, vecs[i].rp});
            chk($sformatf("vec%0d fetch_err", i), {31'b0, fetch_err}, {31'b0, vecs[i].err});
            @(posedge clk); #1;
        end

        // Randomized phase against the reference model, starting from reset.
        rst = 1; exc_req = 0; eret_req = 0; stall = 0;
        @(posedge clk); #1;
        m_pend = 0; m_pend_exc = 0; m_tgt = 0;
        rst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 45);
            br_valid  = $urandom_range(0, 1);
            br_taken  = $urandom_range(0, 1);
            br_target = IMB + ($urandom_range(0, 16'h0FFF) << 2);
            exc_req   = ($urandom_range(0, 99) < 12);
            eret_req  = ($urandom_range(0, 99) < 12);
            epc       = IMB + ($urandom_range(0, 16'h0FFF) << 2);
            if ($urandom_range(0, 9) == 0) pc = $urandom();
            else pc = IMB + ($urandom_range(0, 16'h0FFF) << 2);
            #4;
            if (!rst && (!stall || m_pend)) chk("rand npc", npc, model_npc());
            chk("rand pc_we", {31'b0, pc_we}, {31'b0, (!rst && !stall)});
            chk("rand flush_fd", {31'b0, flush_fd},
                {31'b0, (!rst && !stall && (m_pend || exc_req || eret_req))});
            chk("rand redirect_pending", {31'b0, redirect_pending}, {31'b0, (!rst && m_pend)});
            chk("rand fetch_err", {31'b0, fetch_err}, {31'b0, model_err(pc)});
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
